// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer.
// Holds the chunk width of the adder core, the FSM state encoding and
// the signed-overflow rule applied to the assembled result.
package wide_add_sequencer_pkg;

  // The combinational core processes one byte per pass.
  localparam int CHUNK_W = 8;

  // Sequencer states: waiting for operands, streaming chunks, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Two's-complement overflow: both operands share a sign and the result
  // sign differs from it.
  function automatic logic calc_ovf(input logic sign_a,
                                    input logic sign_b,
                                    input logic sign_sum);
    return (sign_a == sign_b) && (sign_sum != sign_a);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// Combinational 8-bit Kogge-Stone prefix adder core.
// Ports:
//   a, b  : 8-bit addends
//   cin   : carry into bit 0
//   sum   : 8-bit sum
//   cout  : carry out of bit 7
module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Each level doubles the span of the group generate/propagate terms
  // (distances 1, 2, 4); positions whose span already reaches bit 0 pass through.
  for (genvar i = 0; i < 8; i++) begin : g_lvl1
    if (i >= 1) begin : g_op
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
      assign p1[i] = p0[i] & p0[i-1];
    end else begin : g_pass
      assign g1[i] = g0[i];
      assign p1[i] = p0[i];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lvl2
    if (i >= 2) begin : g_op
      assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
      assign p2[i] = p1[i] & p1[i-2];
    end else begin : g_pass
      assign g2[i] = g1[i];
      assign p2[i] = p1[i];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lvl3
    if (i >= 4) begin : g_op
      assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
      assign p3[i] = p2[i] & p2[i-4];
    end else begin : g_pass
      assign g3[i] = g2[i];
      assign p3[i] = p2[i];
    end
  end

  // Carry into bit i+1 is the group generate over [i:0], or the carry-in
  // propagated through the whole group.
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_carry
    assign c[i+1] = g3[i] | (p3[i] & cin);
  end

  assign sum  = p0 ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that streams operands through the
// 8-bit adder core one chunk per cycle, LSB chunk first, chaining the carry
// through a register.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   in_a, in_b            : WIDTH-bit operands
//   in_cin                : carry-in for add (ignored for subtract)
//   in_sub                : 1 selects A - B
//   out_valid / out_ready : result handshake (result held while stalled)
//   out_sum               : WIDTH-bit result
//   out_cout              : final carry (for subtract, 1 = no borrow)
//   out_ovf               : two's-complement signed overflow
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNKS = WIDTH / CHUNK_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_width_check
    $error("wide_add_sequencer: WIDTH must be a multiple of 8 and at least 8");
  end

  seq_state_t       state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, b_eff, res_next;
  logic             carry, sign_a, sign_b;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       core_sum;
  logic             core_cout;
  logic             last_chunk;

  adder u_core (
    .a    (a_sh[CHUNK_W-1:0]),
    .b    (b_sh[CHUNK_W-1:0]),
    .cin  (carry),
    .sum  (core_sum),
    .cout (core_cout)
  );

  // Subtraction is A + ~B + 1, so B is inverted at capture time.
  assign b_eff      = in_sub ? ~in_b : in_b;
  assign last_chunk = (cnt == LAST_CNT);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The result register fills from the top: each new chunk lands in the
  // upper byte so the first (LSB) chunk ends up at the bottom after CHUNKS passes.
  always_comb begin
    res_next = out_sum >> CHUNK_W;
    res_next[WIDTH-1 -: CHUNK_W] = core_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, shift one chunk per RUN cycle, and latch the
  // final carry and overflow on the last pass so they stay stable in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= in_a;
            b_sh   <= b_eff;
            carry  <= in_sub ? 1'b1 : in_cin;
            sign_a <= in_a[WIDTH-1];
            sign_b <= b_eff[WIDTH-1];
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> CHUNK_W;
          b_sh    <= b_sh >> CHUNK_W;
          out_sum <= res_next;
          carry   <= core_cout;
          cnt     <= cnt + 1'b1;
          if (last_chunk) begin
            out_cout <= core_cout;
            out_ovf  <= calc_ovf(sign_a, sign_b, core_sum[CHUNK_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle WIDTH-bit adder/subtractor built on the team's combinational 8-bit prefix adder core (module adder: a[7:0], b[7:0], cin in; sum[7:0], cout out).
- Sits directly upstream of that core and also consumes its outputs. Captures wide operands through a valid/ready handshake and streams them LSB-chunk first through the core, one 8-bit chunk per cycle.
- Chains the carry through a register and presents the assembled result, carry-out and signed overflow on a valid/ready output port.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8 (elaboration error otherwise).
- CHUNKS, WIDTH/8, derived localparam: number of adder passes per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  1 = compute A - B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  final carry-out (for subtract: 1 = no borrow).
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, carry register=0, chunk counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: load a_sh=in_a, b_sh = in_sub ? ~in_b : in_b, carry = in_sub ? 1 : in_cin.
  - Record sign bits in_a[WIDTH-1] and b_eff[WIDTH-1]; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Core inputs: a=a_sh[7:0], b=b_sh[7:0], cin=carry.
  - Each edge: a_sh and b_sh shift right 8; core sum shifts into the top 8 bits of the result register (result shifts right 8); carry=core cout; counter++.
  - After the edge where counter==CHUNKS-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_cout = carry.
  - out_ovf = (signA == signB_eff) && (out_sum[WIDTH-1] != signA).
  - out_sum, out_cout and out_ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: go to IDLE (out_valid drops next cycle).
  - No in-flight overlap: in_ready=0 outside IDLE.
- Latency and throughput:
  - Operands accepted at edge T give out_valid=1 in the cycle following edge T+CHUNKS (WIDTH=32: 4 edges after acceptance).
  - Minimum issue interval is CHUNKS+2 cycles.
- Core path: purely combinational within one cycle; no retiming across it.
- Boundaries:
  - in_valid is ignored outside IDLE. Operands must be held only until the accepting edge.
  - Counter width is $clog2(CHUNKS) with minimum 1; for CHUNKS=1, RUN lasts exactly one cycle.
  - Reset asserted in any state aborts the operation immediately: outputs take reset values, the partial result is discarded, and no out_valid is produced for the aborted operation.
  - out_ready high while not out_valid has no effect.
- Outputs are registered; in_ready and out_valid are decoded from the state register only.

Decomposition:
- Shared package holds:
  - CHUNK_W=8 constant.
  - FSM state enum (IDLE/RUN/DONE, 2-bit encoding).
  - Overflow-compute function.
- One sub-module instance: the existing 8-bit prefix adder core (adder), instantiated once and unmodified.
- All sequencing stays in wide_add_sequencer.

Test Plan:
- Add wrap: WIDTH=32, A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0, out_valid asserted 4 edges after accept.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, cin=0 -> out_sum=0x80000000, cout=0, ovf=1. A=0x80000000, B=0x80000000 -> sum=0x00000000, cout=1, ovf=1.
- Subtract/borrow: A=0x00000005, B=0x00000007, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. A=7, B=5, sub=1 -> sum=0x00000002, cout=1.
- Carry-in and chunk chaining: A=0x00FF00FF, B=0x00010001, cin=1 -> sum=0x01000101, cout=0. Checks carry propagation across each 8-bit chunk boundary.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle, next operand accepted.
- Reset mid-RUN: assert rst asynchronously two cycles after accept -> out_valid=0, in_ready=1 immediately, out_sum=0. The following operation 1+1 yields 0x00000002 with no stale carry.
